// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: read-side controller for fifo_sync.
// Issues fifo_rd_en while the FIFO holds data. Absorbs the FIFO's one-cycle
// registered read latency in a 2-entry buffer. Presents the words as a
// valid/ready stream with a per-burst beat counter and a last flag.
module fifo_rd_streamer #(
   parameter  int WIDTH     = 8,
   parameter  int BURST_LEN = 4,
   localparam int BCW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic [BCW-1:0]   beat_cnt,
   output logic             idle
);

   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

   logic [1:0]       count;     // buffer occupancy 0..2
   logic             inflight;  // a read was issued last cycle
   logic [WIDTH-1:0] buf0;      // head of the buffer
   logic [WIDTH-1:0] buf1;
   logic             pop;
   logic             push;
   logic [2:0]       occ;       // occupancy after this cycle's pop, counting the in-flight word
   logic [1:0]       rem;       // words left after this cycle's pop

   // A word is consumed on a valid/ready handshake. A word arrives from the
   // FIFO whenever a read was issued in the previous cycle.
   assign pop  = m_valid & m_ready;
   assign push = inflight;

   // pop implies count >= 1, so neither subtraction can underflow.
   assign occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
   assign rem = count - {1'b0, pop};

   // Only read when the word is guaranteed a slot on arrival. reset_n gates
   // the strobe so that no read reaches the FIFO while reset is asserted.
   assign fifo_rd_en = enable & reset_n & ~fifo_empty & (occ < 3'd2);

   assign m_valid = (count != 2'd0);
   assign m_data  = buf0;
   assign m_last  = m_valid & (beat_cnt == LAST_BEAT);
   assign idle    = (count == 2'd0) & ~inflight;

   // Track the read in flight and the buffer occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight <= 1'b0;
         count    <= 2'd0;
      end else begin
         inflight <= fifo_rd_en;
         count    <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Shift the head on pop, then place the arriving word behind whatever remains.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf0 <= '0;
         buf1 <= '0;
      end else begin
         if (pop) begin
            buf0 <= buf1;
         end
         if (push) begin
            if (rem == 2'd1) begin
               buf1 <= fifo_dout;
            end else begin
               buf0 <= fifo_dout;
            end
         end
      end
   end

   // Count accepted beats within the current burst, wrapping after the last one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beat_cnt <= '0;
      end else if (pop) begin
         beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end
   end

   // The read-issue rule must keep an arriving word from landing in a full buffer.
   no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(push && (count == 2'd2) && !pop));

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer with a behavioural 4-deep fifo_sync model.
// A scoreboard queue holds every word written into the FIFO model; the
// negedge monitor compares the DUT stream head against it.
module tb_fifo_rd_streamer;

   localparam int WIDTH = 8;
   localparam int BL    = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             enable;
   logic             fifo_empty;
   logic             fifo_rd_en;
   logic [WIDTH-1:0] fifo_dout;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic             m_last;
   logic [1:0]       beat_cnt;
   logic             idle;

   // FIFO model and stimulus controls
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             fake_nonempty;
   logic [WIDTH-1:0] mem [4];
   logic [1:0]       wp, rp;
   logic [2:0]       fcnt;
   logic             f_rd, f_wr;

   // Scoreboard and bookkeeping
   logic [WIDTH-1:0] exp_q [$];
   int               beat_idx;
   int               rd_pulses;
   int               cyc;
   int               first_rd;
   int               first_vld;
   int               nerr;
   int               nchk;

   always #5 clk = ~clk;

   fifo_rd_streamer #(.WIDTH(WIDTH), .BURST_LEN(BL)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .beat_cnt   (beat_cnt),
      .idle       (idle)
   );

   // fifo_sync model: registered dout, reset = ~reset_n
   assign f_rd       = fifo_rd_en && (fcnt != 3'd0);
   assign f_wr       = wr_en && (fcnt != 3'd4);
   assign fifo_empty = fake_nonempty ? 1'b0 : (fcnt == 3'd0);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp        <= '0;
         rp        <= '0;
         fcnt      <= '0;
         fifo_dout <= '0;
      end else begin
         if (f_wr) begin
            mem[wp] <= wr_data;
            wp      <= wp + 2'd1;
         end
         if (f_rd) begin
            fifo_dout <= mem[rp];
            rp        <= rp + 2'd1;
         end
         fcnt <= fcnt + {2'b0, f_wr} - {2'b0, f_rd};
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Monitor: sample mid-cycle, compare the stream head against the scoreboard
   always @(negedge clk) begin
      if (!reset_n) begin
         beat_idx = 0;
      end else begin
         if (fifo_rd_en) begin
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc;
         end
         if (fifo_empty) chk("rd_when_empty", {31'b0, fifo_rd_en}, 32'd0);
         if (m_valid) begin
            if (first_vld < 0) first_vld = cyc;
            if (exp_q.size() == 0) begin
               chk("spurious_valid", 32'd1, 32'd0);
            end else begin
               chk("data", {24'b0, m_data}, {24'b0, exp_q[0]});
               chk("last", {31'b0, m_last}, {31'b0, (beat_idx == BL - 1)});
               chk("beat", {30'b0, beat_cnt}, beat_idx);
               if (m_ready) begin
                  void'(exp_q.pop_front());
                  beat_idx = (beat_idx + 1) % BL;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Write one word into the FIFO model once it has room; record it as expected.
   task automatic fwrite(input logic [WIDTH-1:0] d);
      int n;
      n = 0;
      while (fcnt == 3'd4 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk("write_timeout", 32'd1, 32'd0);
      wr_en   = 1'b1;
      wr_data = d;
      exp_q.push_back(d);
      step();
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(input int max);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && idle) && n < max) begin
         step();
         n++;
      end
      chk("drain_done", {31'b0, (exp_q.size() == 0 && idle)}, 32'd1);
   endtask

   initial begin
      int n;
      nerr = 0; nchk = 0; cyc = 0; beat_idx = 0;
      rd_pulses = 0; first_rd = -1; first_vld = -1;
      reset_n = 1'b0; enable = 1'b1; m_ready = 1'b0;
      wr_en = 1'b0; wr_data = '0; fake_nonempty = 1'b1;

      // 1: reset with FIFO reporting non-empty and enable high
      step(); step();
      chk("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      chk("rst_valid", {31'b0, m_valid}, 32'd0);
      chk("rst_idle",  {31'b0, idle}, 32'd1);
      chk("rst_beat",  {30'b0, beat_cnt}, 32'd0);
      chk("rst_last",  {31'b0, m_last}, 32'd0);
      chk("rst_data",  {24'b0, m_data}, 32'd0);
      fake_nonempty = 1'b0;
      enable        = 1'b0;
      reset_n       = 1'b1;
      step();

      // 2: preload 4, stream 8 words with consumer always ready
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) fwrite(8'h11 + 8'(i));
      first_rd = -1; first_vld = -1;
      enable = 1'b1;
      for (int i = 0; i < 4; i++) fwrite(8'h15 + 8'(i));
      wait_drain(40);
      chk("latency", first_vld - first_rd, 32'd2);

      // 3: consumer stalled -> exactly two reads, head held
      enable = 1'b0; m_ready = 1'b0;
      for (int i = 0; i < 4; i++) fwrite(8'h31 + 8'(i));
      rd_pulses = 0;
      enable = 1'b1;
      repeat (6) step();
      chk("stall_rd_pulses", rd_pulses, 32'd2);
      chk("stall_valid", {31'b0, m_valid}, 32'd1);
      chk("stall_head", {24'b0, m_data}, 32'h31);
      m_ready = 1'b1;
      wait_drain(40);

      // 4: isolated single writes
      rd_pulses = 0;
      fwrite(8'hA0); repeat (4) step();
      fwrite(8'hA1); repeat (4) step();
      fwrite(8'hA2); repeat (4) step();
      chk("single_rd_pulses", rd_pulses, 32'd3);
      wait_drain(20);

      // 5: enable dropped after two reads issued
      enable = 1'b0; m_ready = 1'b0;
      for (int i = 0; i < 4; i++) fwrite(8'h51 + 8'(i));
      rd_pulses = 0;
      enable = 1'b1;
      step(); step();
      enable = 1'b0;
      repeat (4) step();
      chk("en_off_rd_pulses", rd_pulses, 32'd2);
      m_ready = 1'b1;
      n = 0;
      while (!(exp_q.size() == 2 && idle) && n < 20) begin
         step();
         n++;
      end
      chk("en_off_idle", {31'b0, idle}, 32'd1);
      chk("en_off_left", exp_q.size(), 32'd2);
      enable = 1'b1;
      wait_drain(40);

      // 6: async reset with a full buffer mid-burst
      enable = 1'b0; m_ready = 1'b0;
      for (int i = 0; i < 4; i++) fwrite(8'h61 + 8'(i));
      enable = 1'b1; m_ready = 1'b1;
      n = 0;
      while (beat_idx != 2 && n < 40) begin
         step();
         n++;
      end
      m_ready = 1'b0;
      fwrite(8'h65);
      fwrite(8'h66);
      repeat (5) step();
      chk("pre_rst_valid", {31'b0, m_valid}, 32'd1);
      chk("pre_rst_beat", {30'b0, beat_cnt}, 32'd2);
      chk("pre_rst_idle", {31'b0, idle}, 32'd0);
      reset_n = 1'b0;
      #1;
      chk("async_valid", {31'b0, m_valid}, 32'd0);
      chk("async_last",  {31'b0, m_last}, 32'd0);
      chk("async_beat",  {30'b0, beat_cnt}, 32'd0);
      chk("async_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      exp_q.delete();
      step(); step();
      reset_n = 1'b1;
      m_ready = 1'b1;
      step();
      for (int i = 0; i < 4; i++) fwrite(8'h71 + 8'(i));
      wait_drain(40);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
